// File: rtl/pow2_pkg.sv
// Shared definitions for the power-of-two weight path. The MAC array, the encoder and
// any decoder or checker agree on the code layout defined here.
package pow2_pkg;

  localparam int unsigned CODE_W            = 8;
  localparam int unsigned SHIFT_LSB         = 0;
  localparam int unsigned SHIFT_W           = 4;
  localparam int unsigned SIGN_BIT          = 4;
  localparam int unsigned ZERO_BIT          = 5;
  localparam int unsigned MAG_W             = 7;
  localparam int unsigned DEFAULT_MAX_SHIFT = 6;

  typedef logic [SHIFT_W-1:0] shift_t;
  typedef logic [CODE_W-1:0]  code_t;

  // A zero weight always encodes as the bare zero flag, whatever sign/shift say.
  function automatic code_t make_code(input shift_t shift, input logic sign, input logic zero);
    code_t c;
    c = '0;
    if (zero) begin
      c[ZERO_BIT] = 1'b1;
    end else begin
      c[SHIFT_LSB +: SHIFT_W] = shift;
      c[SIGN_BIT]             = sign;
    end
    return c;
  endfunction

endpackage

// File: rtl/pow2_round_lzd.sv
// Leading-one detector with round-half-up and saturation: 7-bit magnitude in,
// 4-bit shift code out. Purely combinational.
module pow2_round_lzd
  import pow2_pkg::*;
#(
  parameter int unsigned MAX_SHIFT = DEFAULT_MAX_SHIFT
) (
  input  logic [MAG_W-1:0] mag,
  output shift_t           shift
);

  localparam shift_t MaxShift = shift_t'(MAX_SHIFT);

  logic [2:0]     lead;
  logic           round_up;
  shift_t         rounded;
  logic [MAG_W:0] mag_ext;

  always_comb begin
    lead = '0;
    for (int i = 1; i < int'(MAG_W); i++) begin
      if (mag[i]) begin
        lead = 3'(i);
      end
    end
    // Extra zero bit keeps the lead-1 index in range when lead is 0.
    mag_ext  = {1'b0, mag};
    round_up = (lead != 3'd0) && mag_ext[lead - 3'd1];
    rounded  = {1'b0, lead} + {3'b000, round_up};
    shift    = (rounded > MaxShift) ? MaxShift : rounded;
  end

endmodule

// File: rtl/pow2_weight_encoder.sv
// Two-stage valid/ready pipeline turning signed 8-bit weights into MAC shift codes,
// tagged with column index, last flag and a vector length error pulse.
module pow2_weight_encoder
  import pow2_pkg::*;
#(
  parameter int unsigned VEC_LEN   = 4,
  parameter int unsigned MAX_SHIFT = DEFAULT_MAX_SHIFT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       w_valid,
  output logic                       w_ready,
  input  logic [7:0]                 w_data,
  input  logic                       w_last,
  output logic                       code_valid,
  input  logic                       code_ready,
  output logic [CODE_W-1:0]          code_data,
  output logic [$clog2(VEC_LEN)-1:0] code_col,
  output logic                       code_last,
  output logic                       len_err
);

  localparam int unsigned      ColW    = $clog2(VEC_LEN);
  localparam logic [ColW-1:0] LastCol = ColW'(VEC_LEN - 1);

  logic s1_adv, s2_adv, w_fire, s1_move;

  logic             in_sign, in_zero, in_err;
  logic [MAG_W-1:0] in_mag;
  logic [ColW-1:0]  idx_q, idx_d;

  logic             s1_valid_q, s1_sign_q, s1_zero_q, s1_err_q;
  logic [MAG_W-1:0] s1_mag_q;
  logic [ColW-1:0]  s1_col_q;

  logic            s2_valid_q, s2_last_q, len_err_q;
  code_t           s2_code_q;
  logic [ColW-1:0] s2_col_q;
  shift_t          s2_shift;

  always_comb begin
    s2_adv  = !s2_valid_q || code_ready;
    s1_adv  = !s1_valid_q || s2_adv;
    w_ready = s1_adv && !reset;
    w_fire  = w_valid && w_ready;
    s1_move = s1_valid_q && s2_adv;
  end

  // -128 has no positive counterpart in 8 bits; it saturates to 127.
  always_comb begin
    in_sign = w_data[7];
    in_zero = (w_data == 8'd0);
    if (!w_data[7]) begin
      in_mag = w_data[6:0];
    end else if (w_data == 8'h80) begin
      in_mag = 7'h7f;
    end else begin
      in_mag = ~w_data[6:0] + 7'd1;
    end
  end

  always_comb begin
    idx_d  = idx_q;
    in_err = 1'b0;
    if (w_fire) begin
      if (w_last) begin
        idx_d  = '0;
        in_err = (idx_q != LastCol);
      end else if (idx_q == LastCol) begin
        idx_d  = '0;
        in_err = 1'b1;
      end else begin
        idx_d = idx_q + ColW'(1);
      end
    end
  end

  pow2_round_lzd #(
    .MAX_SHIFT (MAX_SHIFT)
  ) u_round_lzd (
    .mag   (s1_mag_q),
    .shift (s2_shift)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_zero_q  <= 1'b0;
      s1_err_q   <= 1'b0;
      s1_mag_q   <= '0;
      s1_col_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_code_q  <= '0;
      s2_col_q   <= '0;
      s2_last_q  <= 1'b0;
      len_err_q  <= 1'b0;
    end else begin
      idx_q <= idx_d;
      if (s1_adv) begin
        s1_valid_q <= w_fire;
      end
      if (w_fire) begin
        s1_sign_q <= in_sign;
        s1_zero_q <= in_zero;
        s1_err_q  <= in_err;
        s1_mag_q  <= in_mag;
        s1_col_q  <= idx_q;
      end
      if (s2_adv) begin
        s2_valid_q <= s1_valid_q;
      end
      if (s1_move) begin
        s2_code_q <= make_code(s2_shift, s1_sign_q, s1_zero_q);
        s2_col_q  <= s1_col_q;
        s2_last_q <= (s1_col_q == LastCol);
      end
      // Pulses once, when the offending code lands in the output stage.
      len_err_q <= s1_move && s1_err_q;
    end
  end

  always_comb begin
    code_valid = s2_valid_q;
    code_data  = s2_code_q;
    code_col   = s2_col_q;
    code_last  = s2_last_q;
    len_err    = len_err_q;
  end

endmodule
